// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous SRAM: instruction fetch (read-only) and data port
// (read/write), round-robin on contention, one fully sequenced SRAM cycle in flight at a time.
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              last_mem_q;   // 1: most recent grant went to the data port
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              ce_q, oe_q, we_q;
  logic              if_ack_q, mem_ack_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              pick_mem;

  assign pick_mem = mem_req && (!if_req || !last_mem_q);

  // NOTE: every FSM register is updated with <= so all of them see pre-edge values;
  // the acks get a default clear at the top and are overridden only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_mem_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (if_req || mem_req) begin
            last_mem_q <= pick_mem;
            addr_q     <= pick_mem ? mem_addr : if_addr;
            ce_q       <= 1'b0;
            cnt_q      <= '0;
            if (pick_mem && mem_we) begin
              wdata_q <= mem_wdata;
              drive_q <= 1'b1;
              state_q <= S_WR_SETUP;
            end else begin
              oe_q    <= 1'b0;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt_q == 8'(RD_WAIT - 1)) begin
            if (last_mem_q) mem_rdata_q <= ram_data;
            else            if_rdata_q  <= ram_data;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            if_ack_q  <= !last_mem_q;
            mem_ack_q <= last_mem_q;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WR_SETUP: begin
          we_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt_q == 8'(WR_PULSE - 1)) begin
            we_q    <= 1'b1;
            state_q <= S_WR_HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WR_HOLD: begin
          ce_q      <= 1'b1;
          drive_q   <= 1'b0;
          mem_ack_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_data  = drive_q ? wdata_q : 'z;
  assign ram_addr  = addr_q;
  assign ram_ce    = ce_q;
  assign ram_oe    = oe_q;
  assign ram_we    = we_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default timing instance plus a RD_WAIT=3 / WR_PULSE=2 one,
// each attached to a small behavioural asynchronous SRAM.
module tb_sram_arbiter;

  localparam logic [31:0] PAT = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  int          n_asrt = 0;
  int          n_fail = 0;

  // default instance
  logic        if_req, mem_req, mem_we, if_ack, mem_ack, ram_ce, ram_oe, ram_we;
  logic [19:0] if_addr, mem_addr, ram_addr;
  logic [31:0] mem_wdata, if_rdata, mem_rdata;
  wire  [31:0] ram_data;
  logic        tb_drive;
  logic [31:0] mem_a [4096];

  // slow-timing instance
  logic        b_if_req, b_mem_req, b_mem_we, b_if_ack, b_mem_ack, b_ram_ce, b_ram_oe, b_ram_we;
  logic [19:0] b_if_addr, b_mem_addr, b_ram_addr;
  logic [31:0] b_mem_wdata, b_if_rdata, b_mem_rdata;
  wire  [31:0] b_ram_data;
  logic [31:0] mem_b [4096];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we)
  );

  sram_arbiter #(.RD_WAIT(3), .WR_PULSE(2)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .ram_addr(b_ram_addr), .ram_data(b_ram_data), .ram_ce(b_ram_ce), .ram_oe(b_ram_oe),
    .ram_we(b_ram_we)
  );

  // SRAM models: drive on ce&oe low with we high, latch on the rising edge of we
  assign ram_data   = (!ram_ce && !ram_oe && ram_we) ? mem_a[ram_addr[11:0]] : 'z;
  assign ram_data   = tb_drive ? PAT : 'z;
  assign b_ram_data = (!b_ram_ce && !b_ram_oe && b_ram_we) ? mem_b[b_ram_addr[11:0]] : 'z;

  always @(posedge ram_we)   if (ram_ce === 1'b0)   mem_a[ram_addr[11:0]]   = ram_data;
  always @(posedge b_ram_we) if (b_ram_ce === 1'b0) mem_b[b_ram_addr[11:0]] = b_ram_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A released bus reads back exactly the bench's probe pattern; any other driver corrupts it.
  task automatic check_released(input string tag);
    tb_drive = 1'b1;
    #1;
    check(tag, 64'(ram_data), 64'(PAT));
    tb_drive = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; tb_drive = 1'b0;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_we = 0; b_mem_addr = '0; b_mem_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[12'h010] = 32'hDEAD_BEEF;
    mem_a[12'h020] = 32'hCAFE_F00D;
    repeat (2) tick();

    // reset state
    check("rst_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b111));
    check("rst_addr", 64'(ram_addr), 64'h0);
    check("rst_acks", 64'({if_ack, mem_ack}), 64'h0);
    check("rst_rdata", 64'({if_rdata, mem_rdata}), 64'h0);
    check_released("rst_bus");

    // reset in the middle of a read
    rst = 1'b0; mem_req = 1; mem_we = 0; mem_addr = 20'h00020;
    tick();
    check("rd_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b001));
    check("rd_addr", 64'(ram_addr), 64'h00020);
    rst = 1'b1;
    #1;
    check("abort_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b111));
    check_released("abort_bus");
    tick();
    check("abort_noack", 64'({if_ack, mem_ack}), 64'h0);
    check("abort_nodata", 64'(mem_rdata), 64'h0);

    // both request after release: data port wins first
    if_req = 1; if_addr = 20'h00010;
    rst = 1'b0;
    tick();
    check("first_grant_mem", 64'(ram_addr), 64'h00020);
    check("first_grant_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b001));
    tick();
    check("mem_rd_ack", 64'({if_ack, mem_ack}), 64'(2'b01));
    check("mem_rd_data", 64'(mem_rdata), 64'hCAFE_F00D);
    check("done_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b111));
    check_released("done_bus");
    mem_req = 0;
    tick();
    check("ack_pulse", 64'({if_ack, mem_ack}), 64'h0);

    // fetch read of 0x00010
    tick();
    check("if_rd_addr", 64'(ram_addr), 64'h00010);
    check("if_rd_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b001));
    tick();
    check("if_rd_ack", 64'({if_ack, mem_ack}), 64'(2'b10));
    check("if_rd_data", 64'(if_rdata), 64'hDEAD_BEEF);
    check("if_rd_oe_1cyc", 64'(ram_oe), 64'h1);
    check("mem_rdata_kept", 64'(mem_rdata), 64'hCAFE_F00D);
    if_req = 0;
    tick();
    check("idle_noack", 64'({if_ack, mem_ack}), 64'h0);

    // write 0x12345678 to 0xABCDE
    mem_req = 1; mem_we = 1; mem_addr = 20'hABCDE; mem_wdata = 32'h1234_5678;
    tick();
    check("wr_setup_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b011));
    check("wr_setup_addr", 64'(ram_addr), 64'hABCDE);
    check("wr_setup_data", 64'(ram_data), 64'h1234_5678);
    tick();
    check("wr_pulse_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b010));
    check("wr_pulse_data", 64'(ram_data), 64'h1234_5678);
    tick();
    check("wr_hold_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b011));
    check("wr_hold_data", 64'(ram_data), 64'h1234_5678);
    check("wr_hold_noack", 64'({if_ack, mem_ack}), 64'h0);
    tick();
    check("wr_ack", 64'({if_ack, mem_ack}), 64'(2'b01));
    check("wr_rdata_kept", 64'(mem_rdata), 64'hCAFE_F00D);
    check("wr_stored", 64'(mem_a[12'hCDE]), 64'h1234_5678);
    check_released("wr_done_bus");

    // back-to-back read issued in the ack cycle
    mem_we = 0;
    tick();
    check("b2b_idle_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b111));
    tick();
    check("b2b_grant_pins", 64'({ram_ce, ram_oe, ram_we}), 64'(3'b001));
    check("b2b_grant_addr", 64'(ram_addr), 64'hABCDE);
    tick();
    check("b2b_ack", 64'({if_ack, mem_ack}), 64'(2'b01));
    check("b2b_data", 64'(mem_rdata), 64'h1234_5678);
    mem_req = 0;
    tick();

    // contention after a fresh reset: mem, if, mem, if
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1; if_addr = 20'h00010; mem_req = 1; mem_we = 0; mem_addr = 20'h00020;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant", 64'(ram_addr), (k % 2 == 0) ? 64'h00020 : 64'h00010);
      tick();
      check("rr_ack", 64'({if_ack, mem_ack}), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick();
      check("rr_ack_gap", 64'({if_ack, mem_ack}), 64'h0);
    end
    if_req = 0; mem_req = 0;
    tick();

    // RD_WAIT=3, WR_PULSE=2: write then read back 0x00100
    b_mem_req = 1; b_mem_we = 1; b_mem_addr = 20'h00100; b_mem_wdata = 32'h55AA_33CC;
    tick();
    check("b_setup_pins", 64'({b_ram_ce, b_ram_oe, b_ram_we}), 64'(3'b011));
    tick();
    check("b_pulse1_we", 64'(b_ram_we), 64'h0);
    tick();
    check("b_pulse2_we", 64'(b_ram_we), 64'h0);
    tick();
    check("b_hold_we", 64'(b_ram_we), 64'h1);
    check("b_hold_noack", 64'(b_mem_ack), 64'h0);
    tick();
    check("b_wr_ack", 64'({b_if_ack, b_mem_ack}), 64'(2'b01));
    check("b_wr_stored", 64'(mem_b[12'h100]), 64'h55AA_33CC);
    b_mem_we = 0;
    tick();
    tick();
    check("b_rd_pins", 64'({b_ram_ce, b_ram_oe, b_ram_we}), 64'(3'b001));
    tick();
    check("b_rd_wait1", 64'({b_ram_oe, b_mem_ack}), 64'(2'b00));
    tick();
    check("b_rd_wait2", 64'({b_ram_oe, b_mem_ack}), 64'(2'b00));
    tick();
    check("b_rd_ack", 64'({b_if_ack, b_mem_ack}), 64'(2'b01));
    check("b_rd_data", 64'(b_mem_rdata), 64'h55AA_33CC);
    b_mem_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
